// File: rtl/hpdcache_plru_req_ctrl.sv
// -----------------------------------------------------------------------------
// hpdcache_plru_req_ctrl
//
// Initiator side of the PLRU replacement-state interface. It sits between the
// cache pipeline / refill logic and the PLRU state module:
//   - hit notifications are collected into a small coalescing FIFO and drained
//     as PLRU update requests (updt_*),
//   - victim allocation requests are granted one at a time, forwarded as a
//     replacement request (repl_*), and the victim way chosen by the PLRU module
//     is captured and returned through a registered valid/ready response.
// Allocation always wins over draining hits, so the PLRU module never receives
// an update and a replacement in the same cycle.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   hit_valid_i/ready_o      hit notification handshake
//   hit_set_i, hit_way_i     set index and one-hot way of the hit
//   alloc_req_i/gnt_o        victim allocation request / same-cycle grant
//   alloc_set_i              set to allocate in
//   alloc_dir_valid_i        directory valid bits of that set
//   alloc_updt_plru_i        mark the allocated way as recently used
//   alloc_rsp_valid_o/ready_i victim response handshake
//   alloc_rsp_way_o          one-hot victim way (held while valid)
//   updt_o, updt_set_o, updt_way_o            PLRU update request
//   repl_o, repl_set_o, repl_dir_valid_o,
//   repl_updt_plru_o                          PLRU replacement request
//   victim_way_i             combinational victim from the PLRU module
// -----------------------------------------------------------------------------
module hpdcache_plru_req_ctrl #(
  parameter  int unsigned SETS       = 64,
  parameter  int unsigned WAYS       = 8,
  parameter  int unsigned FIFO_DEPTH = 4,
  localparam int unsigned SW         = (SETS > 1) ? $clog2(SETS) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,

  input  logic            hit_valid_i,
  output logic            hit_ready_o,
  input  logic [SW-1:0]   hit_set_i,
  input  logic [WAYS-1:0] hit_way_i,

  input  logic            alloc_req_i,
  output logic            alloc_gnt_o,
  input  logic [SW-1:0]   alloc_set_i,
  input  logic [WAYS-1:0] alloc_dir_valid_i,
  input  logic            alloc_updt_plru_i,
  output logic            alloc_rsp_valid_o,
  input  logic            alloc_rsp_ready_i,
  output logic [WAYS-1:0] alloc_rsp_way_o,

  output logic            updt_o,
  output logic [SW-1:0]   updt_set_o,
  output logic [WAYS-1:0] updt_way_o,

  output logic            repl_o,
  output logic [SW-1:0]   repl_set_o,
  output logic [WAYS-1:0] repl_dir_valid_o,
  output logic            repl_updt_plru_o,
  input  logic [WAYS-1:0] victim_way_i
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = FIFO_DEPTH[PW:0];
  localparam logic [PW:0] ONE_CNT  = {{PW{1'b0}}, 1'b1};

  typedef enum logic {
    IDLE,
    RSP
  } state_e;

  state_e          r_state;
  state_e          w_nextState;
  logic [WAYS-1:0] r_rspWay;
  logic            w_gnt;

  logic [SW-1:0]   r_setMem [FIFO_DEPTH];
  logic [WAYS-1:0] r_wayMem [FIFO_DEPTH];
  logic [PW:0]     r_wrPtr;
  logic [PW:0]     r_rdPtr;
  logic [PW:0]     w_count;
  logic [PW-1:0]   w_tailIdx;
  logic [PW-1:0]   w_headIdx;
  logic            w_empty;
  logic            w_full;
  logic            w_accept;
  logic            w_coalesce;
  logic            w_push;
  logic            w_pop;

  // Grant only from IDLE. Gating with rst_ni keeps every output at 0 while
  // reset is held, even if a requester is already asserting alloc_req_i.
  always_comb begin
    w_gnt       = 1'b0;
    w_nextState = r_state;
    unique case (r_state)
      IDLE: begin
        w_gnt = rst_ni && alloc_req_i;
        if (w_gnt) begin
          w_nextState = RSP;
        end
      end
      RSP: begin
        if (alloc_rsp_ready_i) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // The victim is sampled in the grant cycle, so the response appears exactly
  // one cycle later and stays frozen for the whole RSP state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= IDLE;
      r_rspWay <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_gnt) begin
        r_rspWay <= victim_way_i;
      end
    end
  end

  // Occupancy comes from the pointer difference; the extra MSB separates full
  // from empty when the index bits match.
  always_comb begin
    w_count   = r_wrPtr - r_rdPtr;
    w_empty   = (r_wrPtr == r_rdPtr);
    w_full    = (w_count == FULL_CNT);
    w_tailIdx = r_wrPtr[PW-1:0] - {{(PW-1){1'b0}}, 1'b1};
    w_headIdx = r_rdPtr[PW-1:0];
    w_accept  = hit_valid_i && hit_ready_o;
    w_pop     = !w_empty && !w_gnt;
    // A hit equal to the tail entry adds nothing to the PLRU state, unless that
    // tail is leaving the FIFO right now, in which case it must be re-queued.
    w_coalesce = !w_empty
              && ({hit_set_i, hit_way_i} == {r_setMem[w_tailIdx], r_wayMem[w_tailIdx]})
              && !(w_pop && (w_count == ONE_CNT));
    w_push    = w_accept && !w_coalesce;
  end

  // FIFO pointers; a simultaneous push and pop leaves the occupancy unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + ONE_CNT;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + ONE_CNT;
      end
    end
  end

  // FIFO storage; contents are only observed through the pointers, so no reset.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_setMem[r_wrPtr[PW-1:0]] <= hit_set_i;
      r_wayMem[r_wrPtr[PW-1:0]] <= hit_way_i;
    end
  end

  // Output drive; data buses read 0 whenever their request strobe is low.
  always_comb begin
    hit_ready_o       = rst_ni && !w_full;
    alloc_gnt_o       = w_gnt;
    alloc_rsp_valid_o = (r_state == RSP);
    alloc_rsp_way_o   = r_rspWay;
    repl_o            = w_gnt;
    repl_set_o        = '0;
    repl_dir_valid_o  = '0;
    repl_updt_plru_o  = 1'b0;
    updt_o            = w_pop;
    updt_set_o        = '0;
    updt_way_o        = '0;
    if (w_gnt) begin
      repl_set_o       = alloc_set_i;
      repl_dir_valid_o = alloc_dir_valid_i;
      repl_updt_plru_o = alloc_updt_plru_i;
    end
    if (w_pop) begin
      updt_set_o = r_setMem[w_headIdx];
      updt_way_o = r_wayMem[w_headIdx];
    end
  end

`ifndef SYNTHESIS
  hitWayOneHot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    hit_valid_i |-> $onehot(hit_way_i));

  victimOneHot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    repl_o |-> $onehot(victim_way_i));

  rspWayStable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (alloc_rsp_valid_o && !alloc_rsp_ready_i) |=> $stable(alloc_rsp_way_o));
`endif

endmodule

// File: tb/tb_hpdcache_plru_req_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hpdcache_plru_req_ctrl
//
// Self-checking bench. A behavioural model (a queue of pending {set,way} hits,
// a "response pending" flag and the captured victim) predicts every output on
// every falling edge; directed scenarios add hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_hpdcache_plru_req_ctrl;

  localparam int SETS  = 64;
  localparam int WAYS  = 8;
  localparam int DEPTH = 4;
  localparam int SW    = 6;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b1;
  logic            hit_valid_i = 1'b0;
  logic            hit_ready_o;
  logic [SW-1:0]   hit_set_i = '0;
  logic [WAYS-1:0] hit_way_i = 8'h01;
  logic            alloc_req_i = 1'b0;
  logic            alloc_gnt_o;
  logic [SW-1:0]   alloc_set_i = '0;
  logic [WAYS-1:0] alloc_dir_valid_i = '0;
  logic            alloc_updt_plru_i = 1'b0;
  logic            alloc_rsp_valid_o;
  logic            alloc_rsp_ready_i = 1'b0;
  logic [WAYS-1:0] alloc_rsp_way_o;
  logic            updt_o;
  logic [SW-1:0]   updt_set_o;
  logic [WAYS-1:0] updt_way_o;
  logic            repl_o;
  logic [SW-1:0]   repl_set_o;
  logic [WAYS-1:0] repl_dir_valid_o;
  logic            repl_updt_plru_o;
  logic [WAYS-1:0] victim_way_i = 8'h01;

  hpdcache_plru_req_ctrl #(
    .SETS       (SETS),
    .WAYS       (WAYS),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .hit_valid_i       (hit_valid_i),
    .hit_ready_o       (hit_ready_o),
    .hit_set_i         (hit_set_i),
    .hit_way_i         (hit_way_i),
    .alloc_req_i       (alloc_req_i),
    .alloc_gnt_o       (alloc_gnt_o),
    .alloc_set_i       (alloc_set_i),
    .alloc_dir_valid_i (alloc_dir_valid_i),
    .alloc_updt_plru_i (alloc_updt_plru_i),
    .alloc_rsp_valid_o (alloc_rsp_valid_o),
    .alloc_rsp_ready_i (alloc_rsp_ready_i),
    .alloc_rsp_way_o   (alloc_rsp_way_o),
    .updt_o            (updt_o),
    .updt_set_o        (updt_set_o),
    .updt_way_o        (updt_way_o),
    .repl_o            (repl_o),
    .repl_set_o        (repl_set_o),
    .repl_dir_valid_o  (repl_dir_valid_o),
    .repl_updt_plru_o  (repl_updt_plru_o),
    .victim_way_i      (victim_way_i)
  );

  always #5 clk_i = ~clk_i;

  int compared   = 0;
  int mismatched = 0;

  // Model state: pending hits in arrival order, response-pending flag, victim.
  logic [SW+WAYS-1:0] mQ[$];
  bit                 mBusy = 1'b0;
  logic [WAYS-1:0]    mRspWay = '0;
  int                 mPushes = 0;
  int                 dutUpdts = 0;
  int                 overlaps = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare on the falling edge, then advance the model to the next rising edge
  // using the inputs that will be sampled there.
  always @(negedge clk_i) begin : compareProc
    logic               eGnt;
    logic               eUpdt;
    logic               eReady;
    logic               accept;
    logic               coalesce;
    logic [SW+WAYS-1:0] hitKey;
    if (!rst_ni) begin
      mQ.delete();
      mBusy   = 1'b0;
      mRspWay = '0;
      checkOutput("rst_gnt",      alloc_gnt_o,       0);
      checkOutput("rst_repl",     repl_o,            0);
      checkOutput("rst_updt",     updt_o,            0);
      checkOutput("rst_hitReady", hit_ready_o,       0);
      checkOutput("rst_rspValid", alloc_rsp_valid_o, 0);
      checkOutput("rst_rspWay",   alloc_rsp_way_o,   0);
    end else begin
      eGnt   = !mBusy && alloc_req_i;
      eUpdt  = (mQ.size() != 0) && !eGnt;
      eReady = (mQ.size() < DEPTH);
      checkOutput("gnt",       alloc_gnt_o,       eGnt);
      checkOutput("repl",      repl_o,            eGnt);
      checkOutput("replSet",   repl_set_o,        eGnt ? alloc_set_i : 0);
      checkOutput("replDir",   repl_dir_valid_o,  eGnt ? alloc_dir_valid_i : 0);
      checkOutput("replPlru",  repl_updt_plru_o,  eGnt ? alloc_updt_plru_i : 0);
      checkOutput("updt",      updt_o,            eUpdt);
      checkOutput("hitReady",  hit_ready_o,       eReady);
      checkOutput("rspValid",  alloc_rsp_valid_o, mBusy);
      if (eUpdt) begin
        checkOutput("updtSet", updt_set_o, mQ[0][SW+WAYS-1:WAYS]);
        checkOutput("updtWay", updt_way_o, mQ[0][WAYS-1:0]);
      end
      if (mBusy) begin
        checkOutput("rspWay", alloc_rsp_way_o, mRspWay);
      end
      if (updt_o) dutUpdts++;
      if (updt_o && repl_o) overlaps++;

      hitKey   = {hit_set_i, hit_way_i};
      accept   = hit_valid_i && eReady;
      coalesce = (mQ.size() != 0) && (mQ[mQ.size()-1] == hitKey)
               && !(eUpdt && mQ.size() == 1);
      if (eUpdt) void'(mQ.pop_front());
      if (accept && !coalesce) begin
        mQ.push_back(hitKey);
        mPushes++;
      end
      if (eGnt) begin
        mBusy   = 1'b1;
        mRspWay = victim_way_i;
      end else if (mBusy && alloc_rsp_ready_i) begin
        mBusy = 1'b0;
      end
    end
  end

  task automatic nextCycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idleCycles(input int n);
    hit_valid_i       = 1'b0;
    alloc_req_i       = 1'b0;
    alloc_rsp_ready_i = 1'b1;
    victim_way_i      = 8'h01;
    repeat (n) nextCycle();
  endtask

  task automatic setHit(input bit v, input int s, input logic [WAYS-1:0] w);
    hit_valid_i = v;
    hit_set_i   = SW'(s);
    hit_way_i   = w;
  endtask

  task automatic applyStimulus();
    hit_valid_i       = 1'($urandom_range(0, 1));
    hit_set_i         = SW'($urandom_range(0, 3));
    hit_way_i         = 8'h01 << $urandom_range(0, 1);
    alloc_req_i       = ($urandom_range(0, 2) == 0);
    alloc_set_i       = SW'($urandom_range(0, SETS - 1));
    alloc_dir_valid_i = WAYS'($urandom);
    alloc_updt_plru_i = 1'($urandom_range(0, 1));
    alloc_rsp_ready_i = 1'($urandom_range(0, 1));
    victim_way_i      = 8'h01 << $urandom_range(0, WAYS - 1);
  endtask

  int cnt;

  initial begin
    // Reset
    #2 rst_ni = 1'b0;
    nextCycle(); nextCycle(); nextCycle();
    rst_ni = 1'b1;
    @(negedge clk_i);
    checkOutput("postRst_hitReady", hit_ready_o, 1);
    checkOutput("postRst_rspValid", alloc_rsp_valid_o, 0);
    nextCycle();

    // Single allocation, response held with ready low
    alloc_req_i = 1'b1; alloc_set_i = 6'd5; alloc_dir_valid_i = 8'hFF; victim_way_i = 8'h04;
    @(negedge clk_i);
    checkOutput("t1_repl",    repl_o,     1);
    checkOutput("t1_replSet", repl_set_o, 5);
    nextCycle();
    victim_way_i = 8'h01; alloc_set_i = '0; alloc_dir_valid_i = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      checkOutput("t1_rspValid", alloc_rsp_valid_o, 1);
      checkOutput("t1_rspWay",   alloc_rsp_way_o,   8'h04);
      checkOutput("t1_gntHeld",  alloc_gnt_o,       0);
      nextCycle();
    end
    idleCycles(2);

    // Three hits drain in order, one cycle after each push
    setHit(1, 3, 8'h01);
    @(negedge clk_i); checkOutput("t2_updt0", updt_o, 0);
    nextCycle(); setHit(1, 7, 8'h02);
    @(negedge clk_i); checkOutput("t2_set1", updt_o ? updt_set_o : 6'h3F, 3);
    checkOutput("t2_way1", updt_way_o, 8'h01);
    nextCycle(); setHit(1, 9, 8'h80);
    @(negedge clk_i); checkOutput("t2_set2", updt_o ? updt_set_o : 6'h3F, 7);
    checkOutput("t2_way2", updt_way_o, 8'h02);
    nextCycle(); setHit(0, 0, 8'h01);
    @(negedge clk_i); checkOutput("t2_set3", updt_o ? updt_set_o : 6'h3F, 9);
    checkOutput("t2_way3", updt_way_o, 8'h80);
    nextCycle();
    @(negedge clk_i); checkOutput("t2_empty", updt_o, 0);
    idleCycles(2);

    // Coalescing: five identical hits behind older entries collapse into one
    cnt = 0;
    alloc_rsp_ready_i = 1'b1;
    for (int c = 0; c < 13; c++) begin
      alloc_req_i = (c >= 1 && c <= 7);
      if (c == 0)      setHit(1, 1, 8'h01);
      else if (c == 1) setHit(1, 2, 8'h02);
      else if (c == 2) setHit(1, 3, 8'h04);
      else if (c <= 7) setHit(1, 4, 8'h10);
      else             setHit(0, 0, 8'h01);
      @(negedge clk_i);
      if (updt_o && updt_set_o == 6'd4 && updt_way_o == 8'h10) cnt++;
      if (c <= 7 && !hit_ready_o) cnt += 100;
      nextCycle();
    end
    checkOutput("t3_singleUpdt", cnt, 1);
    idleCycles(2);

    // Fill the FIFO while allocations repeatedly block the drain
    alloc_rsp_ready_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      alloc_req_i = 1'b1;
      setHit(1, 10 + i, 8'h01 << i);
      if (i == 6) begin
        @(negedge clk_i);
        checkOutput("t4_gntCycleRepl", repl_o, 1);
        checkOutput("t4_gntCycleUpdt", updt_o, 0);
      end
      nextCycle();
    end
    alloc_req_i = 1'b0; setHit(0, 0, 8'h01);
    @(negedge clk_i);
    checkOutput("t4_fullReady", hit_ready_o, 0);
    checkOutput("t4_rspDrain",  updt_o,      1);
    checkOutput("t4_headSet",   updt_set_o,  13);
    nextCycle();
    @(negedge clk_i);
    checkOutput("t4_readyBack", hit_ready_o, 1);
    idleCycles(8);

    // Random contention between allocations and hit draining
    for (int i = 0; i < 400; i++) begin
      applyStimulus();
      nextCycle();
    end
    idleCycles(10);
    checkOutput("t5_noOverlap",   overlaps, 0);
    checkOutput("t5_updtCount",   dutUpdts, mPushes);

    // Asynchronous reset while a response and two hits are pending
    setHit(1, 20, 8'h01); alloc_req_i = 1'b0; alloc_rsp_ready_i = 1'b0;
    nextCycle();
    setHit(1, 21, 8'h02); alloc_req_i = 1'b1; alloc_set_i = 6'd7;
    nextCycle();
    setHit(0, 0, 8'h01); alloc_req_i = 1'b0;
    checkOutput("t6_inRsp",    alloc_rsp_valid_o, 1);
    checkOutput("t6_queued",   updt_o,            1);
    #1 rst_ni = 1'b0;
    #1;
    checkOutput("t6_asyncRspValid", alloc_rsp_valid_o, 0);
    checkOutput("t6_asyncUpdt",     updt_o,            0);
    checkOutput("t6_asyncReady",    hit_ready_o,       0);
    checkOutput("t6_asyncRspWay",   alloc_rsp_way_o,   0);
    nextCycle(); nextCycle();
    rst_ni = 1'b1;
    #1;
    checkOutput("t6_relReady",    hit_ready_o,       1);
    checkOutput("t6_relRspValid", alloc_rsp_valid_o, 0);
    checkOutput("t6_relUpdt",     updt_o,            0);
    idleCycles(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
